// File: rtl/rx_fifo_collect_if.sv
// Byte-collection bus: UART receive strobe/data in, drained byte stream out, plus status.
interface rx_fifo_collect_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          uart_done;
  logic [DW-1:0] uart_dout;
  logic          clear;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [AW:0]   fill_cnt;
  logic          draining;
  logic          frame_done;
  logic          overflow;

  modport master (
    output uart_done, uart_dout, clear, dout_ready,
    input  dout, dout_valid, fill_cnt, draining, frame_done, overflow
  );

  modport slave (
    input  uart_done, uart_dout, clear, dout_ready,
    output dout, dout_valid, fill_cnt, draining, frame_done, overflow
  );
endinterface

// File: rtl/rx_fifo_collect.sv
// Collects a DEPTH-byte frame from the UART receiver, then drains it in order on valid/ready.
// Latency: byte counted next cycle; first drained byte 2 cycles after the last write; stalls hold dout.
module rx_fifo_collect #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  rx_fifo_collect_if.slave bus
);
  typedef enum logic {FILL, DRAIN} state_t;

  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          xfer;
  logic          load;
  logic [AW:0]   pending;

  assign wr_en = (state == FILL) && bus.uart_done && !bus.clear;
  assign xfer  = bus.dout_valid && bus.dout_ready;
  // Bytes still in memory that have not yet been moved into the output register.
  assign pending = bus.fill_cnt - (AW+1)'(bus.dout_valid);
  assign load    = (state == DRAIN) && (pending != '0) && (!bus.dout_valid || bus.dout_ready);

  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.uart_dout;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= FILL;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      bus.fill_cnt   <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.draining   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overflow   <= 1'b0;
    end else if (bus.clear) begin
      state          <= FILL;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      bus.fill_cnt   <= '0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.draining   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overflow   <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      case (state)
        FILL: begin
          if (bus.uart_done) begin
            wr_ptr       <= wr_ptr + 1'b1;
            bus.fill_cnt <= bus.fill_cnt + 1'b1;
            if (bus.fill_cnt == CNT_LAST) begin
              state        <= DRAIN;
              bus.draining <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.uart_done) begin
            bus.overflow <= 1'b1;
          end
          // Registered read straight into the output stage keeps 1 byte/cycle under ready=1.
          if (load) begin
            bus.dout       <= mem[rd_ptr];
            rd_ptr         <= rd_ptr + 1'b1;
            bus.dout_valid <= 1'b1;
          end else if (xfer) begin
            bus.dout_valid <= 1'b0;
          end
          if (xfer) begin
            bus.fill_cnt <= bus.fill_cnt - 1'b1;
            if (bus.fill_cnt == CNT_ONE) begin
              state          <= FILL;
              bus.draining   <= 1'b0;
              bus.frame_done <= 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_fifo_collect.sv
// Directed bench for rx_fifo_collect: frame fill/drain, backpressure, overflow, clear and reset.
module tb_rx_fifo_collect;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = 8;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  rx_fifo_collect_if #(.DW(DW), .AW(AW)) bus ();

  rx_fifo_collect #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          xfer_idx = 0;
  int          frames_seen = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  int          bp_cnt = 0;
  logic        stalled = 1'b0;
  logic [7:0]  held = 8'h00;
  logic        bp_en = 1'b0;
  logic        ready_lvl = 1'b0;
  logic [7:0]  exp_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output-side scoreboard, evaluated mid-cycle.
  task automatic sample();
    cyc++;
    if (!sys_rst_n || bus.clear) begin
      xfer_idx = 0;
      stalled  = 1'b0;
    end else begin
      if (stalled)
        chk("stall_hold", {23'd0, bus.dout_valid, bus.dout}, {23'd0, 1'b1, held});
      if (bus.frame_done) begin
        frames_seen++;
        chk("frame_len", xfer_idx, DEPTH);
        xfer_idx = 0;
      end
      if (bus.dout_valid && bus.dout_ready) begin
        chk("dout", {24'd0, bus.dout}, {24'd0, exp_mem[xfer_idx % DEPTH]});
        chk("fill_cnt_drain", {23'd0, bus.fill_cnt}, DEPTH - xfer_idx);
        if (xfer_idx == 0) first_cyc = cyc;
        last_cyc = cyc;
        xfer_idx++;
      end
      stalled = bus.dout_valid && !bus.dout_ready;
      held    = bus.dout;
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    sample();
    @(posedge sys_clk);
    #1;
    bus.dout_ready = bp_en ? ((bp_cnt % 4 == 0) || (bp_cnt % 4 == 3)) : ready_lvl;
    bp_cnt++;
  endtask

  task automatic set_ready(input logic v);
    ready_lvl      = v;
    bus.dout_ready = v;
  endtask

  function automatic logic [7:0] byte_of(input int mode, input int i);
    logic [7:0] b;
    b = i[7:0];
    case (mode)
      0:       return b;
      1:       return 8'hFF - b;
      default: return 8'h55;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] d, input int gap);
    bus.uart_done = 1'b1;
    bus.uart_dout = d;
    tick();
    bus.uart_done = 1'b0;
    repeat (gap) tick();
  endtask

  // Sends n bytes of a pattern starting from an empty buffer; no gap after the last one.
  task automatic send_bytes(input int mode, input int n, input int gap);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = byte_of(mode, i);
    for (int i = 0; i < n; i++) begin
      send_byte(byte_of(mode, i), 0);
      chk("fill_cnt_write", {23'd0, bus.fill_cnt}, i + 1);
      if (i != n - 1) repeat (gap) tick();
    end
  endtask

  task automatic wait_frame(output int ticks);
    ticks = 0;
    while (!bus.frame_done && ticks < 3000) begin
      tick();
      ticks++;
    end
    chk("frame_done_seen", {31'd0, bus.frame_done}, 32'd1);
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  int t;
  int base;

  initial begin
    bus.uart_done  = 1'b0;
    bus.uart_dout  = '0;
    bus.clear      = 1'b0;
    bus.dout_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("reset_outputs", {11'd0, bus.dout, bus.dout_valid, bus.fill_cnt, bus.draining,
                          bus.frame_done, bus.overflow}, 32'd0);
    sys_rst_n = 1'b1;
    tick();
    chk("post_reset_idle", {11'd0, bus.dout, bus.dout_valid, bus.fill_cnt, bus.draining,
                            bus.frame_done, bus.overflow}, 32'd0);

    // Frame with no backpressure, 10-cycle byte spacing
    set_ready(1'b1);
    base = frames_seen;
    send_bytes(0, DEPTH, 9);
    chk("drain_entry", {bus.draining, bus.dout_valid, bus.fill_cnt}, {1'b1, 1'b0, 9'd256});
    tick();
    chk("first_valid", {bus.dout_valid, bus.dout}, {1'b1, 8'h00});
    wait_frame(t);
    chk("frame_done_latency", t, 256);
    chk("end_of_frame", {bus.draining, bus.dout_valid, bus.fill_cnt, bus.overflow}, 12'd0);
    tick();
    chk("frame_done_single", {31'd0, bus.frame_done}, 32'd0);
    chk("consecutive_bytes", last_cyc - first_cyc, 255);
    chk("frames_t1", frames_seen - base, 1);

    // Backpressure 1,0,0,1
    base  = frames_seen;
    bp_en = 1'b1;
    send_bytes(0, DEPTH, 9);
    wait_frame(t);
    tick();
    bp_en = 1'b0;
    set_ready(1'b1);
    chk("frames_bp", frames_seen - base, 1);
    chk("overflow_bp", {31'd0, bus.overflow}, 32'd0);

    // Overflow: drop three bytes while a full frame is stalled
    set_ready(1'b0);
    base = frames_seen;
    send_bytes(0, DEPTH, 2);
    repeat (2) tick();
    chk("ovf_before", {31'd0, bus.overflow}, 32'd0);
    send_byte(8'hAA, 0);
    chk("ovf_first_drop", {bus.overflow, bus.fill_cnt}, {1'b1, 9'd256});
    send_byte(8'hAA, 3);
    send_byte(8'hAA, 3);
    chk("ovf_fill_unchanged", {bus.fill_cnt, bus.dout_valid, bus.dout}, {9'd256, 1'b1, 8'h00});
    set_ready(1'b1);
    wait_frame(t);
    tick();
    chk("frames_ovf", frames_seen - base, 1);
    chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
    pulse_clear();
    chk("ovf_cleared", {bus.overflow, bus.fill_cnt}, 10'd0);

    // Clear mid-fill, then a frame of 0x55
    send_bytes(0, 100, 2);
    tick();
    pulse_clear();
    chk("clear_fill", {bus.fill_cnt, bus.draining}, 10'd0);
    base = frames_seen;
    send_bytes(2, DEPTH, 2);
    wait_frame(t);
    tick();
    chk("frames_clear", frames_seen - base, 1);

    // Reset after 40 drained bytes
    send_bytes(1, DEPTH, 2);
    t = 0;
    while (xfer_idx < 40 && t < 2000) begin
      tick();
      t++;
    end
    chk("reached_40", {31'd0, xfer_idx >= 40}, 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_reset", {11'd0, bus.dout, bus.dout_valid, bus.fill_cnt, bus.draining,
                        bus.frame_done, bus.overflow}, 32'd0);
    tick();
    sys_rst_n = 1'b1;
    tick();

    // Two back-to-back frames; second starts in the frame_done cycle
    base = frames_seen;
    send_bytes(1, DEPTH, 2);
    wait_frame(t);
    send_bytes(1, DEPTH, 2);
    wait_frame(t);
    tick();
    chk("frames_b2b", frames_seen - base, 2);

    // clear together with the 256th uart_done
    send_bytes(0, DEPTH - 1, 2);
    bus.uart_done = 1'b1;
    bus.uart_dout = 8'hFF;
    bus.clear     = 1'b1;
    tick();
    bus.uart_done = 1'b0;
    bus.clear     = 1'b0;
    chk("clr_win", {bus.fill_cnt, bus.draining, bus.overflow}, 11'd0);
    repeat (3) tick();
    chk("clr_no_drain", {bus.draining, bus.dout_valid, bus.fill_cnt}, 11'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rx_fifo_collect.md
# rx_fifo_collect

Collects the byte stream from the UART receiver (`uart_dout`/`uart_done`) into a 256 x 8 on-chip buffer. When a full frame of 256 bytes has been captured, the block drains the frame in order on a valid/ready output port for the logic-analyzer capture path. It then re-arms for the next frame. It sits directly downstream of `uart_rx` in the loopback test design and replaces hand-wired FIFO control signals.

## Interface
- `DEPTH`, 256: frame length and buffer depth; must be a power of two.
- `AW`, 8: address width, log2(`DEPTH`).
- `DW`, 8: data width.

- `sys_clk`  in  1  system clock; all logic is on the rising edge.
- `sys_rst_n`  in  1  reset, asynchronous and active-low.
- `uart_done`  in  1  one-cycle pulse: `uart_dout` holds a new received byte.
- `uart_dout`  in  `DW`  received byte; sampled only when `uart_done`=1.
- `clear`  in  1  synchronous restart. It has priority over all inputs except reset.
- `dout`  out  `DW`  drained byte.
- `dout_valid`  out  1  `dout` is valid.
- `dout_ready`  in  1  the consumer accepts `dout`. A transfer occurs when `dout_valid` and `dout_ready` are both 1 in the same cycle.
- `fill_cnt`  out  `AW`+1  number of bytes stored and not yet drained (0..`DEPTH`).
- `draining`  out  1  high while in DRAIN.
- `frame_done`  out  1  one-cycle pulse after the last byte of a frame is transferred.
- `overflow`  out  1  sticky flag: a byte was dropped.

## Operation
- States: FILL and DRAIN.
- Reset or `clear` puts the block in this state:
  - state FILL;
  - write and read pointers 0;
  - `fill_cnt`=0;
  - `dout`=0, `dout_valid`=0, `draining`=0;
  - `frame_done`=0, `overflow`=0.
- FILL:
  - Each `uart_done` writes `uart_dout` to mem[wr_ptr]. `wr_ptr` increments (mod `DEPTH`) and `fill_cnt` increments.
  - The write that makes `fill_cnt`=`DEPTH` moves the state to DRAIN on the same edge. `wr_ptr` wraps to 0.
- DRAIN:
  - Bytes are presented in write order, mem[0] through mem[DEPTH-1].
  - Each transfer decrements `fill_cnt`.
  - Sustained throughput is 1 byte/cycle while `dout_ready`=1. The implementation must prefetch, because the memory read is registered.
  - While `dout_valid`=1 and `dout_ready`=0, `dout` holds stable and `dout_valid` stays high.
  - `dout_valid` never deasserts without a transfer, except on `clear` or reset.
- End of frame:
  - On the transfer of byte index `DEPTH`-1, `dout_valid` drops on the next edge.
  - `frame_done` pulses for exactly that following cycle.
  - The state returns to FILL and `fill_cnt`=0.
- `uart_done` during DRAIN: the byte is discarded and `overflow` is set. `overflow` stays set until `clear` or reset.
- `uart_done` in the same cycle as `clear`: `clear` wins. The byte is discarded and `overflow` is not set.
- Arithmetic: pointers wrap naturally at `AW` bits. `fill_cnt` never exceeds `DEPTH` and never underflows.

## Timing
- Write latency: a `uart_done` at cycle t is reflected in `fill_cnt` at t+1.
- DRAIN entry: the 256th `uart_done` at cycle t gives `draining`=1 at t+1 and the first `dout_valid`=1 at t+2, with `dout`=mem[0].
- With `dout_ready` held at 1, bytes 0..255 appear on 256 consecutive cycles, t+2 .. t+257.
  - `frame_done`=1 at t+258.
  - `draining`=0 and `dout_valid`=0 at t+258.
- The first byte of the next frame may be accepted at t+258.
- `clear` asserted at cycle t: every output takes its reset value at t+1.
- Asynchronous reset mid-DRAIN: outputs go to their reset values immediately. The buffer contents are don't-care.

## Test plan
- Frame with no backpressure:
  - Stimulus: 256 `uart_done` pulses spaced 10 cycles apart, data 0x00..0xFF; `dout_ready`=1.
  - Required: `dout` = 0x00..0xFF on consecutive cycles; a single `frame_done`; `fill_cnt` reads 256 then counts down to 0; `overflow`=0.
- Backpressure:
  - Stimulus: the same frame; `dout_ready` toggles 1,0,0,1 repeating.
  - Required: every byte transferred exactly once, in order; `dout` stable across every stalled cycle; 256 transfers in total.
- Overflow:
  - Stimulus: 3 `uart_done` pulses (0xAA) during DRAIN.
  - Required: the frame output is unchanged (0x00..0xFF); `overflow`=1 after the first dropped byte; `fill_cnt` unaffected by the dropped bytes; after `clear`, `overflow`=0.
- `clear` mid-fill:
  - Stimulus: 100 bytes, then `clear`, then 256 bytes of value 0x55.
  - Required: `fill_cnt`=0 after `clear`; the drained frame is 256 x 0x55.
- Reset mid-DRAIN, then back-to-back frames:
  - Stimulus: assert `sys_rst_n`=0 after 40 drained bytes, release it, then send two consecutive frames of 0xFF..0x00.
  - Required: after reset, all outputs are 0; each later frame drains 0xFF..0x00 with one `frame_done` per frame.
- Simultaneous `clear` and `uart_done` in FILL with `fill_cnt`=255:
  - Required: no DRAIN entry; `fill_cnt`=0; `overflow`=0.
